// File: rtl/spatz_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spatz_issue_ctrl
// Brief    : Vector front-end issue controller. It owns the vl/vtype/vstart
//            CSRs, executes vsetvl-style configuration (draining in-flight
//            ops first), serves vector CSR accesses and forwards all other
//            ops through a one-entry issue register with in-flight tracking.
// Revision : 1.0 - initial release
// ============================================================================

package spatz_issue_pkg;

   typedef enum logic [1:0] {
      OP_VCFG = 2'd0,
      OP_VCSR = 2'd1,
      OP_VADD = 2'd2,
      OP_VLE  = 2'd3
   } op_e;

   typedef struct packed {
      logic       vill;
      logic       vma;
      logic       vta;
      logic [2:0] vsew;
      logic [2:0] vlmul;
   } vtype_t;

   typedef struct packed {
      op_e         op;
      logic [31:0] rs1;
      logic [11:0] csr_addr;
      logic        keep_vl;
      logic        write_vstart;
      logic        set_vstart;
      logic        clear_vstart;
      logic        reset_vstart;
      logic        use_rd;
      vtype_t      vtype;
      logic [31:0] vl;
      logic [31:0] vstart;
   } spatz_req_t;

endpackage

module spatz_issue_ctrl
   import spatz_issue_pkg::*;
#(
   parameter int unsigned VLEN      = 512,
   parameter int unsigned ELEN      = 32,
   parameter int unsigned NrPending = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  spatz_req_t      req_i,
   input  logic            req_illegal_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   output spatz_req_t      issue_o,
   output logic            issue_valid_o,
   input  logic            issue_ready_i,
   input  logic            issue_done_i,
   output logic [ELEN-1:0] rsp_data_o,
   output logic            rsp_error_o,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i
);

   localparam int unsigned c_CNT_W     = $clog2(NrPending + 1);
   localparam logic [31:0] c_VLENB     = 32'(VLEN / 8);
   localparam vtype_t      c_VTYPE_ILL = vtype_t'(9'h100);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, RSP = 2'd2} state_e;

   state_e             r_state, w_state_next;
   vtype_t             r_vtype;
   logic [31:0]        r_vl, r_vstart;
   logic [c_CNT_W-1:0] r_pending, w_pending_next;
   spatz_req_t         r_issue, w_issue_next;
   logic               r_issue_valid;
   logic [7:0]         r_cfg_vt;
   logic [31:0]        r_cfg_rs1;
   logic               r_cfg_keep;
   logic [31:0]        r_rsp_data;
   logic               r_rsp_error;
   logic               r_rdy_en;

   logic               w_accept, w_issue_fire, w_done;
   logic [7:0]         w_cfg_vt;
   logic [31:0]        w_cfg_rs1, w_avl, w_vlmax, w_new_vl;
   logic               w_cfg_keep, w_cfg_bad;
   vtype_t             w_new_vtype;
   logic               w_do_cfg, w_latch_cfg, w_csr_write, w_load_issue, w_rsp_load;
   logic [31:0]        w_vstart_new, w_rsp_data_next;
   logic               w_rsp_err_next;

   assign req_ready_o   = r_rdy_en && (r_state == IDLE) && !r_issue_valid;
   assign w_accept      = req_valid_i && req_ready_o;
   // An op waiting in the issue register is held back while the in-flight window is full.
   assign issue_valid_o = r_issue_valid && (r_pending != c_CNT_W'(NrPending));
   assign issue_o       = r_issue;
   assign w_issue_fire  = issue_valid_o && issue_ready_i;
   assign w_done        = issue_done_i && (r_pending != '0);
   assign rsp_valid_o   = (r_state == RSP);
   assign rsp_data_o    = ELEN'(r_rsp_data);
   assign rsp_error_o   = r_rsp_error;

   // In-flight counter update: issue handshakes add, retirements subtract.
   always_comb begin
      w_pending_next = r_pending;
      if (w_issue_fire && !w_done) begin
         w_pending_next = r_pending + c_CNT_W'(1);
      end else if (!w_issue_fire && w_done) begin
         w_pending_next = r_pending - c_CNT_W'(1);
      end
   end

   // Configuration result for either the live request or the one parked in DRAIN.
   always_comb begin
      w_cfg_vt    = (r_state == DRAIN) ? r_cfg_vt   : req_i.vtype[7:0];
      w_cfg_rs1   = (r_state == DRAIN) ? r_cfg_rs1  : req_i.rs1;
      w_cfg_keep  = (r_state == DRAIN) ? r_cfg_keep : req_i.keep_vl;
      // Reserved SEW, SEW wider than ELEN, or fractional/reserved LMUL.
      w_cfg_bad   = w_cfg_vt[5] || ((32'd8 << w_cfg_vt[5:3]) > ELEN) || w_cfg_vt[2];
      w_vlmax     = (32'(VLEN) >> (32'd3 + 32'(w_cfg_vt[4:3]))) << w_cfg_vt[1:0];
      w_avl       = w_cfg_keep ? r_vl : w_cfg_rs1;
      w_new_vl    = w_cfg_bad ? 32'd0 : ((w_avl < w_vlmax) ? w_avl : w_vlmax);
      w_new_vtype = w_cfg_bad ? c_VTYPE_ILL : vtype_t'({1'b0, w_cfg_vt});
   end

   // Issue entry carries the request with the CSR snapshot taken at acceptance.
   always_comb begin
      w_issue_next        = req_i;
      w_issue_next.vtype  = r_vtype;
      w_issue_next.vl     = r_vl;
      w_issue_next.vstart = r_vstart;
   end

   // Next-state and per-cycle actions of the control FSM.
   always_comb begin
      w_state_next    = r_state;
      w_do_cfg        = 1'b0;
      w_latch_cfg     = 1'b0;
      w_csr_write     = 1'b0;
      w_vstart_new    = r_vstart;
      w_load_issue    = 1'b0;
      w_rsp_load      = 1'b0;
      w_rsp_data_next = '0;
      w_rsp_err_next  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (req_illegal_i ||
                   (r_vtype.vill && (req_i.op != OP_VCFG) && (req_i.op != OP_VCSR))) begin
                  w_rsp_load     = 1'b1;
                  w_rsp_err_next = 1'b1;
                  w_state_next   = RSP;
               end else if (req_i.op == OP_VCFG) begin
                  if (r_pending == '0) begin
                     w_do_cfg        = 1'b1;
                     w_rsp_load      = 1'b1;
                     w_rsp_data_next = w_new_vl;
                     w_state_next    = RSP;
                  end else begin
                     w_latch_cfg  = 1'b1;
                     w_state_next = DRAIN;
                  end
               end else if (req_i.op == OP_VCSR) begin
                  w_rsp_load   = 1'b1;
                  w_state_next = RSP;
                  unique case (req_i.csr_addr)
                     12'h008: begin
                        w_rsp_data_next = r_vstart;
                        w_csr_write     = 1'b1;
                        if (req_i.write_vstart) begin
                           w_vstart_new = req_i.rs1;
                        end else if (req_i.set_vstart) begin
                           w_vstart_new = r_vstart | req_i.rs1;
                        end else if (req_i.clear_vstart) begin
                           w_vstart_new = r_vstart & ~req_i.rs1;
                        end
                     end
                     12'hC20: w_rsp_data_next = r_vl;
                     12'hC21: w_rsp_data_next = 32'(r_vtype);
                     12'hC22: w_rsp_data_next = c_VLENB;
                     default: w_rsp_err_next  = 1'b1;
                  endcase
               end else begin
                  w_load_issue = 1'b1;
                  if (req_i.use_rd) begin
                     w_rsp_load   = 1'b1;
                     w_state_next = RSP;
                  end
               end
            end
         end
         DRAIN: begin
            if (w_pending_next == '0) begin
               w_do_cfg        = 1'b1;
               w_rsp_load      = 1'b1;
               w_rsp_data_next = w_new_vl;
               w_state_next    = RSP;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // CSRs, in-flight counter, issue entry, parked configuration and response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdy_en      <= 1'b0;
         r_vl          <= '0;
         r_vtype       <= c_VTYPE_ILL;
         r_vstart      <= '0;
         r_pending     <= '0;
         r_issue       <= '0;
         r_issue_valid <= 1'b0;
         r_cfg_vt      <= '0;
         r_cfg_rs1     <= '0;
         r_cfg_keep    <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_error   <= 1'b0;
      end else begin
         r_rdy_en  <= 1'b1;
         r_pending <= w_pending_next;
         if (w_do_cfg) begin
            r_vl     <= w_new_vl;
            r_vtype  <= w_new_vtype;
            r_vstart <= '0;
         end else if (w_csr_write) begin
            r_vstart <= w_vstart_new;
         end else if (w_issue_fire && r_issue.reset_vstart) begin
            r_vstart <= '0;
         end
         if (w_load_issue) begin
            r_issue       <= w_issue_next;
            r_issue_valid <= 1'b1;
         end else if (w_issue_fire) begin
            r_issue_valid <= 1'b0;
         end
         if (w_latch_cfg) begin
            r_cfg_vt   <= req_i.vtype[7:0];
            r_cfg_rs1  <= req_i.rs1;
            r_cfg_keep <= req_i.keep_vl;
         end
         if (w_rsp_load) begin
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_error <= w_rsp_err_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/spatz_issue_ctrl.md
SPATZ_ISSUE_CTRL -- requirements
Module: spatz_issue_ctrl

Interface
REQ-001 SHALL have parameters: VLEN, default 512, bits per vector register; ELEN, default 32, max element bits; NrPending, default 8, max in-flight issued ops.
REQ-002 SHALL have ports, in order:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- req_i, in, spatz_req_t, decoded request.
- req_illegal_i, in, 1, decoder flagged illegal.
- req_valid_i, in, 1, request valid.
- req_ready_o, out, 1, request accepted.
- issue_o, out, spatz_req_t, request to execution units.
- issue_valid_o, out, 1, issue valid.
- issue_ready_i, in, 1, issue accepted.
- issue_done_i, in, 1, one op retired.
- rsp_data_o, out, ELEN, scalar result for rd.
- rsp_error_o, out, 1, instruction illegal.
- rsp_valid_o, out, 1, response valid.
- rsp_ready_i, in, 1, response accepted.

Function
REQ-003 SHALL hold CSRs vl, vtype and vstart; a request is accepted when req_valid_i && req_ready_o.
REQ-004 SHALL use FSM states IDLE, DRAIN and RSP; req_ready_o SHALL be 1 only in IDLE with no stalled issue entry.
REQ-005 VCFG handling:
- If pending == 0, SHALL be executed on acceptance.
- Otherwise SHALL be latched, FSM to DRAIN, executed the cycle pending reaches 0.
REQ-006 VCFG SHALL compute vlmax = (VLEN/SEW)*LMUL, with LMUL in {1,2,4,8}.
REQ-007 VCFG with SEW > ELEN, fractional/reserved LMUL or reserved SEW SHALL set:
- vtype = {vill=1, rest 0}
- vl = 0
REQ-008 VCFG new vl:
- keep_vl=1: vl = min(vl, vlmax).
- Otherwise: vl = min(rs1, vlmax), comparison unsigned at full ELEN width.
REQ-009 VCFG SHALL clear vstart, return the new vl on rsp_data_o, and move FSM to RSP.
REQ-010 VCSR SHALL complete on acceptance, FSM to RSP, rsp_data_o = old CSR value:
- addr 0x008 vstart: write_vstart → vstart = rs1; set_vstart → vstart |= rs1; clear_vstart → vstart &= ~rs1.
- addr 0xC20 vl, 0xC21 vtype, 0xC22 vlenb = VLEN/8: read-only.
- Any other addr: rsp_error_o = 1, data 0, no state change.
REQ-011 Illegal requests SHALL go to RSP with rsp_error_o = 1 and no state change:
- req_illegal_i = 1.
- Any non-VCFG/VCSR op while vtype.vill = 1.
REQ-012 Other ops SHALL load a one-entry issue register:
- issue_o = req_i with vtype, vl, vstart overwritten by current CSRs.
- Entry persists until issue_ready_i.
REQ-013 When an issued op has reset_vstart set, vstart SHALL be cleared on the issue_valid_o && issue_ready_i cycle.
REQ-014 An issued op with use_rd = 1 SHALL also produce a response (data 0) before the next acceptance.
REQ-015 Pending counter:
- +1 on issue handshake; −1 on issue_done_i.
- Simultaneous +1/−1: unchanged.
- issue_done_i at 0: ignored.
- Issue stalls (issue_valid_o held low) while pending == NrPending.
REQ-016 RSP SHALL hold rsp_valid_o, rsp_data_o and rsp_error_o stable until rsp_ready_i, then return to IDLE the same edge.
REQ-017 Latency SHALL be:
- CSR/VCFG response (no drain): rsp_valid_o 1 cycle after acceptance.
- Issue: issue_valid_o 1 cycle after acceptance.
REQ-018 issue_valid_o SHALL never deassert without a handshake, and issue_o SHALL be stable while valid.

Reset
REQ-019 On rst_ni low, asynchronously:
- vl = 0, vtype = {vill=1, rest 0}, vstart = 0.
- pending = 0, FSM = IDLE.
- issue_valid_o = 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_error_o = 0, req_ready_o = 0 until first edge after release.
REQ-020 Reset mid-DRAIN or mid-RSP SHALL discard the latched request and its response.

Verification
REQ-021 Bench SHALL cover these directed scenarios (VLEN = 512):
- VCFG SEW=32, LMUL=2, rs1=100 → rsp 32, vl=32, vill=0.
- VCFG SEW=64 → rsp 0, vill=1; following VADD → rsp_error_o=1, no issue.
- Two VADDs issued, then VCFG → held in DRAIN until two issue_done_i pulses, rsp 1 cycle after.
- VCSR read 0xC22 → 64; set_vstart rs1=5 → returns 0, vstart=5; VLE with reset_vstart issues vstart=5 then vstart=0.
- issue_ready_i low 3 cycles → issue_o stable, req_ready_o low; 9 ops with no done → 9th stalls at NrPending.
- rst_ni asserted during RSP → rsp_valid_o=0 immediately, CSRs at reset values.
